spi_dac_responder: RTL and testbench

Synthesizable SPI responder that emulates the 24-bit-frame DAC register interface driven by the DAC ramping and control blocks. It receives frames on sck/ss_L/mosi in the system clock domain, decodes the 4-bit command, updates an internal 20-bit DAC register on writes, and returns register contents on the following frame after a read command. It sits opposite the SPI master in simulation benches and in FPGA self-test builds, so the ramp logic can be exercised without an external DAC.

---
 rtl/spi_dac_responder.sv | 176 +++++++++++++++++
 tb/tb_spi_dac_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/spi_dac_responder.sv
// SPI responder emulating a 24-bit-frame DAC register interface.
// Optional readback path: define SPI_DAC_RESPONDER_READBACK_EN.
module spi_dac_responder #(
  parameter int DAC_WID      = 24,
  parameter int DAC_DATA_WID = 20,
  parameter bit POLARITY     = 1'b0,
  parameter bit PHASE        = 1'b1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic                    sck,
  input  logic                    ss_L,
  input  logic                    mosi,
  output logic                    miso,
  output logic [DAC_DATA_WID-1:0] dac_value,
  output logic [DAC_DATA_WID-1:0] ctrl_reg,
  output logic                    write_stb,
  output logic                    frame_err
);

  localparam int CMD_WID = DAC_WID - DAC_DATA_WID;
  localparam int CNT_W   = $clog2(DAC_WID + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DAC_WID);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DAC_WID + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
  logic sck_s, ss_s, mosi_s;
  logic sck_q, ss_q;
  logic lead, trail, sample, ss_fall, ss_rise;

  logic [CNT_W-1:0]   cnt;
  logic [DAC_WID-1:0] sr;
  logic [CMD_WID-1:0] cmd;
  logic [DAC_DATA_WID-1:0] data;
  logic [2:0] addr;
  logic is_read, frame_ok;

  // ss chain resets to "asserted" so a low ss_L at release never looks like a fall
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      sck_sync  <= {SYNC_STAGES{POLARITY}};
      ss_sync   <= '0;
      mosi_sync <= '0;
      sck_q     <= POLARITY;
      ss_q      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_L};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_q     <= sck_s;
      ss_q      <= ss_s;
    end
  end

  assign sck_s   = sck_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign lead    = (sck_s != sck_q) && (sck_s != POLARITY);
  assign trail   = (sck_s != sck_q) && (sck_s == POLARITY);
  assign sample  = PHASE ? trail : lead;
  assign ss_fall = ~ss_s & ss_q;
  assign ss_rise = ss_s & ~ss_q;

  assign cmd      = sr[DAC_WID-1:DAC_DATA_WID];
  assign data     = sr[DAC_DATA_WID-1:0];
  assign addr     = cmd[2:0];
  assign is_read  = cmd[CMD_WID-1];
  assign frame_ok = (cnt == CNT_FULL);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    write_stb = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      IDLE:   if (ss_fall) state_n = SHIFT;
      SHIFT:  if (ss_rise) state_n = COMMIT;
      COMMIT: begin
        state_n = IDLE;
        if (frame_ok) write_stb = ~is_read && (addr == 3'd1);
        else          frame_err = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cnt       <= '0;
      sr        <= '0;
      dac_value <= '0;
      ctrl_reg  <= '0;
    end else begin
      case (state)
        IDLE: if (ss_fall) begin
          cnt <= '0;
          sr  <= '0;
        end
        SHIFT: if (sample) begin
          sr <= {sr[DAC_WID-2:0], mosi_s};
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
        COMMIT: if (frame_ok && !is_read) begin
          if (addr == 3'd1) dac_value <= data;
          if (addr == 3'd2) ctrl_reg  <= data;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_DAC_RESPONDER_READBACK_EN
  logic [DAC_WID-1:0]      pend, tx;
  logic [DAC_DATA_WID-1:0] rd_data;
  logic                    miso_q, launch;

  assign launch = PHASE ? lead : trail;

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (addr == 3'd1): rd_data = dac_value;
      (addr == 3'd2): rd_data = ctrl_reg;
      default:        rd_data = '0;
    endcase
  end

  // pending word is consumed by the frame that starts after it
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      pend   <= '0;
      tx     <= '0;
      miso_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          miso_q <= 1'b0;
          if (ss_fall) begin
            pend <= '0;
            if (PHASE) tx <= pend;
            else       {miso_q, tx} <= {pend, 1'b0};
          end
        end
        SHIFT: if (launch) begin
          miso_q <= tx[DAC_WID-1];
          tx     <= {tx[DAC_WID-2:0], 1'b0};
        end
        COMMIT: begin
          miso_q <= 1'b0;
          if (!frame_ok)    pend <= '0;
          else if (is_read) pend <= {cmd, rd_data};
        end
        default: ;
      endcase
    end
  end

  assign miso = miso_q & ~ss_L;
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_responder.sv
// Directed bench for spi_dac_responder (SPI mode POL=0, PHA=1).
module tb_spi_dac_responder;

  localparam int HALF = 6;
`ifdef SPI_DAC_RESPONDER_READBACK_EN
  localparam logic [31:0] RB_EXP = 32'h0098_0000;
`else
  localparam logic [31:0] RB_EXP = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst_L, sck, ss_L, mosi, miso;
  logic [19:0] dac_value, ctrl_reg;
  logic write_stb, frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stb   = 0;
  int n_err   = 0;
  int b_stb, b_err;
  logic [31:0] rx;

  always #5 clk = ~clk;

  spi_dac_responder dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .sck       (sck),
    .ss_L      (ss_L),
    .mosi      (mosi),
    .miso      (miso),
    .dac_value (dac_value),
    .ctrl_reg  (ctrl_reg),
    .write_stb (write_stb),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (write_stb) n_stb++;
    if (frame_err) n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    b_stb = n_stb;
    b_err = n_err;
  endtask

  task automatic send_frame(input logic [23:0] word, input int nbits,
                            output logic [31:0] got);
    got  = '0;
    ss_L = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 24) ? word[23-i] : 1'b0;
      sck  = 1'b1;
      wait_cyc(HALF);
      got  = {got[30:0], miso};
      sck  = 1'b0;
      wait_cyc(HALF);
    end
    wait_cyc(HALF);
    ss_L = 1'b1;
    mosi = 1'b0;
    wait_cyc(10);
  endtask

  initial begin
    rst_L = 1'b0;
    sck   = 1'b0;
    ss_L  = 1'b1;
    mosi  = 1'b0;
    wait_cyc(4);
    check("rst_miso", {31'b0, miso}, 32'h0);
    check("rst_dac", {12'b0, dac_value}, 32'h0);
    check("rst_ctrl", {12'b0, ctrl_reg}, 32'h0);
    check("rst_stb", {31'b0, write_stb}, 32'h0);
    check("rst_err", {31'b0, frame_err}, 32'h0);
    rst_L = 1'b1;
    wait_cyc(10);

    mark();
    send_frame(24'h112345, 24, rx);
    check("wr1_dac", {12'b0, dac_value}, 32'h12345);
    check("wr1_stb", n_stb - b_stb, 1);
    check("wr1_err", n_err - b_err, 0);

    mark();
    send_frame(24'h180000, 24, rx);
    check("wr2_dac", {12'b0, dac_value}, 32'h80000);
    check("wr2_stb", n_stb - b_stb, 1);
    mark();
    send_frame(24'h900000, 24, rx);
    check("rd_err", n_err - b_err, 0);
    check("rd_stb", n_stb - b_stb, 0);
    send_frame(24'h000000, 24, rx);
    check("rb_miso", rx & 32'hFF_FFFF, RB_EXP);
    check("rb_dac", {12'b0, dac_value}, 32'h80000);
    send_frame(24'h000000, 24, rx);
    check("rb_consumed", rx & 32'hFF_FFFF, 32'h0);
    check("nop_stb", n_stb - b_stb, 0);

    mark();
    send_frame(24'h1FFFFF, 23, rx);
    check("short_err", n_err - b_err, 1);
    check("short_stb", n_stb - b_stb, 0);
    check("short_dac", {12'b0, dac_value}, 32'h80000);

    mark();
    send_frame(24'h1FFFFF, 25, rx);
    check("long_err", n_err - b_err, 1);
    check("long_dac", {12'b0, dac_value}, 32'h80000);

    mark();
    send_frame(24'h200002, 24, rx);
    check("ctrl_val", {12'b0, ctrl_reg}, 32'h2);
    check("ctrl_dac", {12'b0, dac_value}, 32'h80000);
    check("ctrl_stb", n_stb - b_stb, 0);

    mark();
    ss_L = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < 12; i++) begin
      mosi = (i == 3) ? 1'b1 : 1'b0;
      sck  = 1'b1;
      wait_cyc(HALF);
      sck  = 1'b0;
      wait_cyc(HALF);
    end
    rst_L = 1'b0;
    wait_cyc(3);
    ss_L = 1'b1;
    mosi = 1'b0;
    wait_cyc(3);
    rst_L = 1'b1;
    wait_cyc(10);
    check("abort_stb", n_stb - b_stb, 0);
    check("abort_err", n_err - b_err, 0);
    check("abort_dac", {12'b0, dac_value}, 32'h0);
    check("abort_ctrl", {12'b0, ctrl_reg}, 32'h0);
    mark();
    send_frame(24'h100010, 24, rx);
    check("post_dac", {12'b0, dac_value}, 32'h10);
    check("post_stb", n_stb - b_stb, 1);
    check("post_err", n_err - b_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
